// File: rtl/wt_dcache_mem_responder_if.sv
// Request/return bus between the write-through dcache and its memory-side
// responder. The master modport is the cache side, the slave modport is the
// memory model. dbg_state exposes the responder FSM state for observation.
//
// Handshake: a request transfers on a rising clock edge where req_valid_i and
// req_ready_o are both high. The requester holds all req_* fields stable while
// req_valid_i is high and not yet accepted. Returns are single-cycle pulses
// on rtrn_valid_o with no backpressure.
interface wt_dcache_mem_responder_if #(
    parameter int AddrWidth   = 64,
    parameter int LineWidth   = 128,
    parameter int MemTidWidth = 2
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic                   req_rtype_i;
    logic                   req_nc_i;
    logic [MemTidWidth-1:0] req_tid_i;
    logic [AddrWidth-1:0]   req_paddr_i;
    logic [1:0]             req_size_i;
    logic [63:0]            req_data_i;
    logic                   rtrn_valid_o;
    logic                   rtrn_rtype_o;
    logic [MemTidWidth-1:0] rtrn_tid_o;
    logic [LineWidth-1:0]   rtrn_data_o;
    logic                   busy_o;
    logic [1:0]             dbg_state;

    modport master (
        output req_valid_i, req_rtype_i, req_nc_i, req_tid_i, req_paddr_i,
               req_size_i, req_data_i,
        input  req_ready_o, rtrn_valid_o, rtrn_rtype_o, rtrn_tid_o,
               rtrn_data_o, busy_o, dbg_state
    );

    modport slave (
        input  req_valid_i, req_rtype_i, req_nc_i, req_tid_i, req_paddr_i,
               req_size_i, req_data_i,
        output req_ready_o, rtrn_valid_o, rtrn_rtype_o, rtrn_tid_o,
               rtrn_data_o, busy_o, dbg_state
    );
endinterface

// File: rtl/wt_dcache_mem_responder.sv
// Memory-side responder for the write-through dcache. Requests are queued in
// a small FIFO and answered in order after a fixed latency: loads return a
// cache line (or one word when non-cacheable), stores return an ack.
// Optional macro BIG_ENDIAN_SWAP_EN: reverse byte order within every 64-bit
// word on store data and load data, and mirror byte-enable lanes.
module wt_dcache_mem_responder #(
    parameter int AddrWidth    = 64,
    parameter int LineWidth    = 128,
    parameter int MemTidWidth  = 2,
    parameter int MemWords     = 4096,
    parameter int ReqFifoDepth = 4,
    parameter int Latency      = 2
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    wt_dcache_mem_responder_if.slave  bus
);
    localparam int IdxW  = AddrWidth - 3;
    localparam int MemAw = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int Words = LineWidth / 64;
    localparam int PtrW  = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
    localparam int CntW  = (Latency > 1) ? $clog2(Latency) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic                   rtype;
        logic                   nc;
        logic [MemTidWidth-1:0] tid;
        logic [AddrWidth-1:0]   paddr;
        logic [1:0]             size;
        logic [63:0]            data;
    } req_t;

    // Byte reversal within a 64-bit word when the NoC side is big-endian.
    function automatic logic [63:0] swap64(input logic [63:0] w);
        logic [63:0] r;
`ifdef BIG_ENDIAN_SWAP_EN
        for (int b = 0; b < 8; b++) r[8*b +: 8] = w[8*(7-b) +: 8];
`else
        r = w;
`endif
        return r;
    endfunction

    function automatic logic [7:0] swap_be(input logic [7:0] be);
        logic [7:0] r;
`ifdef BIG_ENDIAN_SWAP_EN
        for (int b = 0; b < 8; b++) r[b] = be[7-b];
`else
        r = be;
`endif
        return r;
    endfunction

    req_t            fifo_q [ReqFifoDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic [1:0]      state_q;
    logic [CntW-1:0] cnt_q;
    req_t            hold_q;
    logic [63:0]     mem_q [MemWords];

    logic full, empty, push, pop;
    req_t req_in;

    assign full  = (count_q == (PtrW+1)'(ReqFifoDepth));
    assign empty = (count_q == '0);
    assign push  = bus.req_valid_i && !full;
    assign pop   = (state_q == ST_IDLE) && !empty;

    assign req_in = '{rtype: bus.req_rtype_i, nc: bus.req_nc_i, tid: bus.req_tid_i,
                      paddr: bus.req_paddr_i, size: bus.req_size_i, data: bus.req_data_i};

    // FIFO payload storage; contents need no reset since count gates reads.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= req_in;
    end

    // FIFO pointers and occupancy; push and pop may happen in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Service FSM: pop into the holding register, wait Latency cycles, respond.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        hold_q  <= fifo_q[rd_ptr_q];
                        cnt_q   <= CntW'(Latency - 1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) state_q <= ST_RESP;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Decode of the held request.
    logic [IdxW-1:0] hold_idx, line_base;
    logic [2:0]      hold_off;
    logic            in_range, misaligned, store_en, resp;
    logic [7:0]      be, unused_be_hi;
    logic [7:0]      be_eff;
    logic [63:0]     wdata_eff;

    assign hold_idx  = hold_q.paddr[AddrWidth-1:3];
    assign hold_off  = hold_q.paddr[2:0];
    assign line_base = hold_idx & ~IdxW'(Words - 1);
    assign in_range  = (hold_idx < IdxW'(MemWords));
    assign resp      = (state_q == ST_RESP);
    assign {unused_be_hi, be} = ((16'd1 << (5'd1 << hold_q.size)) - 16'd1) << hold_off;
    assign be_eff    = swap_be(be);
    assign wdata_eff = swap64(hold_q.data);

    // A store not aligned to its own size is acked but writes nothing.
    always_comb begin
        misaligned = 1'b0;
        case (hold_q.size)
            2'd1:    misaligned = hold_off[0];
            2'd2:    misaligned = |hold_off[1:0];
            2'd3:    misaligned = |hold_off;
            default: misaligned = 1'b0;
        endcase
    end

    assign store_en = resp && hold_q.rtype && in_range && !misaligned;

    // Backing store write with byte enables at the end of the RESP cycle.
    always_ff @(posedge clk_i) begin
        if (store_en) begin
            for (int b = 0; b < 8; b++) begin
                if (be_eff[b]) mem_q[hold_idx[MemAw-1:0]][8*b +: 8] <= wdata_eff[8*b +: 8];
            end
        end
    end

    // Load return data; zero outside RESP, for store acks and out-of-range words.
    logic [LineWidth-1:0] rdata;
    logic [IdxW-1:0]      widx;
    always_comb begin
        rdata = '0;
        widx  = '0;
        if (resp && !hold_q.rtype) begin
            if (hold_q.nc) begin
                if (in_range) rdata[63:0] = swap64(mem_q[hold_idx[MemAw-1:0]]);
            end else begin
                for (int k = 0; k < Words; k++) begin
                    widx = line_base + IdxW'(k);
                    if (widx < IdxW'(MemWords)) rdata[64*k +: 64] = swap64(mem_q[widx[MemAw-1:0]]);
                end
            end
        end
    end

    assign bus.req_ready_o  = !full;
    assign bus.rtrn_valid_o = resp;
    assign bus.rtrn_rtype_o = resp && hold_q.rtype;
    assign bus.rtrn_tid_o   = resp ? hold_q.tid : '0;
    assign bus.rtrn_data_o  = rdata;
    assign bus.busy_o       = !empty || (state_q != ST_IDLE);
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
// Self-checking bench for wt_dcache_mem_responder (default parameters,
// Latency=2). A reference memory model computes each response when the
// request is driven; the monitor pops and compares when the return appears.
module tb_wt_dcache_mem_responder;
    localparam int AW  = 64;
    localparam int LW  = 128;
    localparam int TW  = 2;
    localparam int MW  = 4096;
    localparam int LAT = 2;
    localparam int EW  = 1 + TW + LW;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wt_dcache_mem_responder_if #(.AddrWidth(AW), .LineWidth(LW), .MemTidWidth(TW)) bus_if ();

    wt_dcache_mem_responder #(
        .AddrWidth(AW), .LineWidth(LW), .MemTidWidth(TW),
        .MemWords(MW), .ReqFifoDepth(4), .Latency(LAT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_resp_cyc = -1;
    int last_acc_cyc  = 0;
    bit stall_seen    = 0;
    logic [EW-1:0] exp_q[$];
    logic [63:0] model [longint unsigned];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] mget(input longint unsigned idx);
        if (idx >= MW) return 64'h0;
        if (!model.exists(idx)) return 64'h0;
        return model[idx];
    endfunction

    // Reference behaviour: updates the model for stores, builds the expected return.
    function automatic logic [EW-1:0] model_resp(input bit rt, input bit nc, input logic [TW-1:0] tid,
                                                 input logic [63:0] pa, input logic [1:0] sz,
                                                 input logic [63:0] d);
        logic [LW-1:0] data;
        longint unsigned idx, base;
        int nbytes, off;
        logic [63:0] w;
        data   = '0;
        idx    = pa >> 3;
        nbytes = 1 << sz;
        off    = int'(pa[2:0]);
        if (rt) begin
            if (idx < MW && (off % nbytes) == 0) begin
                w = mget(idx);
                for (int b = 0; b < nbytes; b++) w[8*(off+b) +: 8] = d[8*(off+b) +: 8];
                model[idx] = w;
            end
        end else if (nc) begin
            data[63:0] = mget(idx);
        end else begin
            base = idx & ~longint'(1);
            data[63:0]   = mget(base);
            data[127:64] = mget(base + 1);
        end
        return {rt, tid, data};
    endfunction

    // driver
    task automatic send(input bit rt, input bit nc, input logic [TW-1:0] tid, input logic [63:0] pa,
                        input logic [1:0] sz, input logic [63:0] d);
        int waited;
        waited = 0;
        bus_if.req_valid_i = 1'b1;
        bus_if.req_rtype_i = rt;
        bus_if.req_nc_i    = nc;
        bus_if.req_tid_i   = tid;
        bus_if.req_paddr_i = pa;
        bus_if.req_size_i  = sz;
        bus_if.req_data_i  = d;
        while (!bus_if.req_ready_o) begin
            stall_seen = 1'b1;
            @(negedge clk);
            waited++;
            if (waited > 100) begin
                check("ready_timeout", waited, 0);
                bus_if.req_valid_i = 1'b0;
                return;
            end
        end
        exp_q.push_back(model_resp(rt, nc, tid, pa, sz, d));
        last_acc_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus_if.busy_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("idle_timeout", n, 0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (bus_if.rtrn_valid_o) begin
            last_resp_cyc = cyc;
            check("rtrn_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rtrn_rtype", bus_if.rtrn_rtype_o, e[EW-1]);
                check("rtrn_tid", bus_if.rtrn_tid_o, e[EW-2 -: TW]);
                check("rtrn_data", bus_if.rtrn_data_o, e[LW-1:0]);
            end
        end else begin
            check("idle_data_zero", bus_if.rtrn_data_o, 0);
        end
    end

    initial begin
        logic [63:0] pa, d;
        bus_if.req_valid_i = 1'b0;
        bus_if.req_rtype_i = 1'b0;
        bus_if.req_nc_i    = 1'b0;
        bus_if.req_tid_i   = '0;
        bus_if.req_paddr_i = '0;
        bus_if.req_size_i  = '0;
        bus_if.req_data_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus_if.req_ready_o, 1);
        check("rst_valid", bus_if.rtrn_valid_o, 0);
        check("rst_rtype", bus_if.rtrn_rtype_o, 0);
        check("rst_tid", bus_if.rtrn_tid_o, 0);
        check("rst_busy", bus_if.busy_o, 0);
        check("rst_state", bus_if.dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: store then cacheable load, with latency check
        send(1, 0, 2'd1, 64'h100, 2'd3, 64'h1122334455667788);
        wait_idle();
        check("store_latency", last_resp_cyc - last_acc_cyc, LAT + 2);
        send(1, 0, 2'd3, 64'h108, 2'd3, 64'h0);
        wait_idle();
        send(0, 0, 2'd2, 64'h100, 2'd0, 64'h0);
        wait_idle();
        check("load_latency", last_resp_cyc - last_acc_cyc, LAT + 2);

        // Test 2: byte store into a zero word, halfword store, nc and line loads
        send(1, 0, 2'd0, 64'h100, 2'd3, 64'h0);
        send(1, 0, 2'd1, 64'h103, 2'd0, 64'h00000000AB000000);
        send(0, 1, 2'd2, 64'h100, 2'd0, 64'h0);
        send(1, 0, 2'd3, 64'h10C, 2'd1, 64'h0000BEEF00000000);
        send(0, 0, 2'd0, 64'h108, 2'd0, 64'h0);
        wait_idle();

        // Test 3: back-to-back burst fills the FIFO and stalls
        for (int i = 0; i < 8; i++) send(1, 0, TW'(i), 64'h300 + 64'(8*i), 2'd3, {$urandom, $urandom});
        wait_idle();
        stall_seen = 1'b0;
        send(1, 0, 2'd0, 64'h300, 2'd3, 64'hA5A5A5A5_00000001);
        send(0, 0, 2'd1, 64'h300, 2'd0, 64'h0);
        send(1, 0, 2'd2, 64'h318, 2'd2, 64'h12345678_00000000);
        send(0, 1, 2'd3, 64'h318, 2'd0, 64'h0);
        send(1, 0, 2'd0, 64'h308, 2'd0, 64'h00000000_0000005A);
        send(0, 0, 2'd1, 64'h308, 2'd0, 64'h0);
        check("fifo_full_stall", stall_seen, 1);
        wait_idle();

        // Random mix within the initialised window 0x300..0x33F
        repeat (30) begin
            pa = 64'h300 + 64'($urandom_range(0, 63));
            d  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'($urandom_range(0, 3)),
                 pa, 2'($urandom_range(0, 3)), d);
        end
        wait_idle();

        // Test 4: out-of-range and misaligned accesses
        send(0, 0, 2'd1, 64'(MW) * 8, 2'd0, 64'h0);
        send(0, 1, 2'd2, 64'(MW) * 8 + 8, 2'd0, 64'h0);
        send(1, 0, 2'd3, 64'(MW) * 8, 2'd3, 64'hFFFFFFFFFFFFFFFF);
        send(1, 0, 2'd0, 64'h102, 2'd2, 64'hDEADBEEFDEADBEEF);
        send(0, 1, 2'd1, 64'h100, 2'd0, 64'h0);
        wait_idle();

        // Test 5: reset while in WAIT with two entries queued
        send(0, 1, 2'd0, 64'h100, 2'd0, 64'h0);
        send(0, 1, 2'd1, 64'h108, 2'd0, 64'h0);
        send(0, 1, 2'd2, 64'h300, 2'd0, 64'h0);
        check("pre_rst_state", bus_if.dbg_state, 1);
        check("pre_rst_busy", bus_if.busy_o, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_busy", bus_if.busy_o, 0);
        check("mid_rst_ready", bus_if.req_ready_o, 1);
        check("mid_rst_valid", bus_if.rtrn_valid_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_state", bus_if.dbg_state, 0);
        check("post_rst_busy", bus_if.busy_o, 0);

`ifdef BIG_ENDIAN_SWAP_EN
        // Test 6: big-endian byte swap of stored and returned words
        send(1, 0, 2'd1, 64'h200, 2'd3, 64'h0102030405060708);
        send(0, 1, 2'd2, 64'h200, 2'd0, 64'h0);
        wait_idle();
        check("internal_swapped", dut.mem_q[64], 64'h0807060504030201);
`endif

        // final report
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
